// File: rtl/md_hazard_ctrl_pkg.sv
// Shared widths, Tnew/Tuse encodings and mult/div latency defaults for the pipeline
// hazard controller and its mult/div busy counter.
package md_hazard_ctrl_pkg;

  localparam int TNEW_W = 4;
  localparam int MD_CNT_W = 4;

  // A Tuse of all-ones marks an operand as not read; no Tnew can exceed it.
  localparam logic [TNEW_W-1:0] TUSE_NONE = '1;

  typedef enum logic [TNEW_W-1:0] {
    T_ALU = 4'd0,
    T_MEM = 4'd1,
    T_WB  = 4'd2
  } tstage_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_busy_counter.sv
// Mult/div busy countdown: zero-latency busy from the count register, done/err are
// one-cycle registered pulses; starts while busy are dropped and flagged on md_err.
module md_busy_counter
  import md_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CW          = MD_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic e_md_start,
  input  logic e_md_is_div,
  output logic md_busy,
  output logic md_done,
  output logic md_err
);

  logic [CW-1:0] md_cnt;
  logic          md_cnt_is_zero;

  assign md_cnt_is_zero = (md_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt  <= '0;
      md_done <= 1'b0;
      md_err  <= 1'b0;
    end else begin
      // Done fires in the cycle after the 1 -> 0 step; a start at count 1 is ignored.
      md_done <= (md_cnt == CW'(1));
      md_err  <= e_md_start && !md_cnt_is_zero;
      if (e_md_start && md_cnt_is_zero) begin
        md_cnt <= e_md_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (!md_cnt_is_zero) begin
        md_cnt <= md_cnt - CW'(1);
      end
    end
  end

  assign md_busy = !md_cnt_is_zero;

endmodule

// File: rtl/md_hazard_ctrl.sv
// Pipeline hazard controller: combinational (zero-latency) RAW and mult/div stall,
// freezing PC/D and bubbling E while the D-stage instruction cannot proceed.
module md_hazard_ctrl
  import md_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int TW          = TNEW_W,
  parameter int CW          = MD_CNT_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    d_rs,
  input  logic [4:0]    d_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic          d_md_use,
  input  logic [4:0]    e_regsel,
  input  logic          e_regwrite,
  input  logic [TW-1:0] e_tnew,
  input  logic [4:0]    m_regsel,
  input  logic          m_regwrite,
  input  logic [TW-1:0] m_tnew,
  input  logic          e_md_start,
  input  logic          e_md_is_div,
  output logic          stall,
  output logic          pc_en,
  output logic          d_en,
  output logic          e_flush,
  output logic          md_busy,
  output logic          md_done,
  output logic          md_err
);

  logic hz_rs;
  logic hz_rt;
  logic md_stall;

  // A producer only blocks the consumer if its result arrives later than it is needed.
  assign hz_rs = (d_rs != 5'd0) &&
                 ((e_regwrite && (e_regsel == d_rs) && (e_tnew > d_tuse_rs)) ||
                  (m_regwrite && (m_regsel == d_rs) && (m_tnew > d_tuse_rs)));

  assign hz_rt = (d_rt != 5'd0) &&
                 ((e_regwrite && (e_regsel == d_rt) && (e_tnew > d_tuse_rt)) ||
                  (m_regwrite && (m_regsel == d_rt) && (m_tnew > d_tuse_rt)));

  // The start cycle itself counts as busy so a HI/LO user directly behind mult/div waits.
  assign md_stall = d_md_use && (e_md_start || md_busy);

  assign stall   = hz_rs | hz_rt | md_stall;
  assign pc_en   = ~stall;
  assign d_en    = ~stall;
  assign e_flush = stall;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CW          (CW)
  ) u_md_cnt (
    .clk         (clk),
    .reset       (reset),
    .e_md_start  (e_md_start),
    .e_md_is_div (e_md_is_div),
    .md_busy     (md_busy),
    .md_done     (md_done),
    .md_err      (md_err)
  );

endmodule

// File: tb/tb_md_hazard_ctrl.sv
// Directed bench for md_hazard_ctrl: RAW hazards, $0, mult/div timing, illegal start,
// asynchronous reset mid-countdown and combined hazards.
module tb_md_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] d_rs, d_rt, e_regsel, m_regsel;
  logic [3:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic       d_md_use, e_regwrite, m_regwrite, e_md_start, e_md_is_div;
  logic       stall, pc_en, d_en, e_flush, md_busy, md_done, md_err;

  int total = 0;
  int bad   = 0;

  md_hazard_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .d_rs        (d_rs),
    .d_rt        (d_rt),
    .d_tuse_rs   (d_tuse_rs),
    .d_tuse_rt   (d_tuse_rt),
    .d_md_use    (d_md_use),
    .e_regsel    (e_regsel),
    .e_regwrite  (e_regwrite),
    .e_tnew      (e_tnew),
    .m_regsel    (m_regsel),
    .m_regwrite  (m_regwrite),
    .m_tnew      (m_tnew),
    .e_md_start  (e_md_start),
    .e_md_is_div (e_md_is_div),
    .stall       (stall),
    .pc_en       (pc_en),
    .d_en        (d_en),
    .e_flush     (e_flush),
    .md_busy     (md_busy),
    .md_done     (md_done),
    .md_err      (md_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    d_rs = 5'd0; d_rt = 5'd0;
    d_tuse_rs = 4'hF; d_tuse_rt = 4'hF;
    d_md_use = 1'b0;
    e_regsel = 5'd0; e_regwrite = 1'b0; e_tnew = 4'd0;
    m_regsel = 5'd0; m_regwrite = 1'b0; m_tnew = 4'd0;
    e_md_start = 1'b0; e_md_is_div = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    #12;
    chk("rst_busy", md_busy, 0);
    chk("rst_done", md_done, 0);
    chk("rst_err", md_err, 0);
    chk("rst_stall", stall, 0);
    chk("rst_pc_en", pc_en, 1);
    @(negedge clk);
    reset = 1'b1;

    // Load-use: lw $5 in E, addu reading $5 in D.
    @(negedge clk);
    e_regsel = 5'd5; e_regwrite = 1'b1; e_tnew = 4'd2;
    d_rs = 5'd5; d_tuse_rs = 4'd1;
    #1;
    chk("lu_stall", stall, 1);
    chk("lu_flush", e_flush, 1);
    chk("lu_pc_en", pc_en, 0);
    chk("lu_d_en", d_en, 0);
    @(negedge clk);
    e_regwrite = 1'b0; e_regsel = 5'd0; e_tnew = 4'd0;
    m_regsel = 5'd5; m_regwrite = 1'b1; m_tnew = 4'd1;
    #1;
    chk("lu_next_stall", stall, 0);
    chk("lu_next_pc_en", pc_en, 1);

    // $0 never stalls; Tnew==Tuse does not stall; not-read operand never stalls.
    @(negedge clk);
    idle_inputs();
    e_regsel = 5'd0; e_regwrite = 1'b1; e_tnew = 4'd2;
    d_rs = 5'd0; d_tuse_rs = 4'd0;
    #1;
    chk("zero_reg", stall, 0);
    e_regsel = 5'd7; d_rt = 5'd7; d_tuse_rt = 4'hF;
    #1;
    chk("rt_unused", stall, 0);
    d_tuse_rt = 4'd1;
    #1;
    chk("rt_e_haz", stall, 1);
    e_tnew = 4'd1;
    #1;
    chk("rt_equal", stall, 0);
    idle_inputs();
    m_regsel = 5'd9; m_regwrite = 1'b1; m_tnew = 4'd2; d_rt = 5'd9; d_tuse_rt = 4'd0;
    #1;
    chk("rt_m_haz", stall, 1);
    m_regwrite = 1'b0;
    #1;
    chk("rt_m_nowr", stall, 0);

    // Mult: start with mflo in D; busy for 5 sampled cycles, then done.
    @(negedge clk);
    idle_inputs();
    e_md_start = 1'b1; d_md_use = 1'b1;
    #1;
    chk("mul_start_stall", stall, 1);
    chk("mul_start_busy", md_busy, 0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      e_md_start = 1'b0;
      #1;
      chk($sformatf("mul_busy%0d", i), md_busy, 1);
      chk($sformatf("mul_stall%0d", i), stall, 1);
      chk($sformatf("mul_done%0d", i), md_done, 0);
    end
    @(negedge clk);
    #1;
    chk("mul_end_busy", md_busy, 0);
    chk("mul_end_done", md_done, 1);
    chk("mul_end_stall", stall, 0);
    @(negedge clk);
    #1;
    chk("mul_done_clr", md_done, 0);

    // Div with an illegal start during the count.
    @(negedge clk);
    idle_inputs();
    e_md_start = 1'b1; e_md_is_div = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      e_md_start = (i == 3);
      #1;
      chk($sformatf("div_busy%0d", i), md_busy, 1);
      chk($sformatf("div_err%0d", i), md_err, (i == 4) ? 1 : 0);
    end
    @(negedge clk);
    #1;
    chk("div_end_busy", md_busy, 0);
    chk("div_end_done", md_done, 1);
    chk("div_end_err", md_err, 0);

    // Reset mid-div aborts the count without a clock edge.
    @(negedge clk);
    idle_inputs();
    e_md_start = 1'b1; e_md_is_div = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      e_md_start = 1'b0;
    end
    #1;
    chk("rdiv_busy_pre", md_busy, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rdiv_busy_async", md_busy, 0);
    chk("rdiv_done_async", md_done, 0);
    @(negedge clk);
    reset = 1'b1;
    d_md_use = 1'b1;
    #1;
    chk("rdiv_mfhi_stall", stall, 0);
    @(negedge clk);
    #1;
    chk("rdiv_busy_after", md_busy, 0);
    chk("rdiv_done_after", md_done, 0);

    // Dual hazard: rs RAW from E plus HI/LO use while busy.
    @(negedge clk);
    idle_inputs();
    e_md_start = 1'b1;
    @(negedge clk);
    e_md_start = 1'b0;
    d_rs = 5'd3; d_tuse_rs = 4'd0;
    e_regsel = 5'd3; e_regwrite = 1'b1; e_tnew = 4'd1;
    d_md_use = 1'b1;
    #1;
    chk("dual_busy", md_busy, 1);
    chk("dual_stall", stall, 1);
    d_md_use = 1'b0;
    #1;
    chk("dual_gpr_only", stall, 1);
    d_rs = 5'd4;
    #1;
    chk("dual_none", stall, 0);
    d_md_use = 1'b1;
    #1;
    chk("dual_md_only", stall, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
